// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings and a
// helper that classifies which operations use the iterative engine.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_MUL = 3'b110,
        OP_DIV = 3'b111
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } alu_state_e;

    function automatic logic is_multicycle(alu_op_e op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) engine.
// Ports: clk, rst (async, active high); load latches a/b/op_is_div;
// step advances one iteration; step_done acknowledges the step;
// step_result is the register value after the current step
// (product for MUL, {remainder, quotient} for DIV).
module seq_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               op_is_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               step_done,
    output logic [2*WIDTH-1:0] step_result
);

    // p holds {acc, multiplier} for MUL and {remainder, dividend} for
    // DIV; m holds the multiplicand or the divisor.
    logic [2*WIDTH-1:0] p;
    logic [WIDTH-1:0]   m;
    logic               div;

    logic [WIDTH-1:0]   p_hi;
    logic [WIDTH:0]     acc;
    logic [WIDTH:0]     rs;
    logic               ge;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;

    assign p_hi = p[2*WIDTH-1:WIDTH];

    // Shift-add: add multiplicand into the upper half when the current
    // multiplier LSB is set, then shift the whole register right.
    assign acc      = {1'b0, p_hi}
                    + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    assign mul_next = {acc, p[WIDTH-1:1]};

    // Restoring divide: shift the next dividend bit into the remainder
    // and subtract when it fits. rs - m < m, so the low WIDTH bits of
    // the subtraction are exact.
    assign rs       = {p_hi, p[WIDTH-1]};
    assign ge       = (rs >= {1'b0, m});
    assign rem_next = ge ? (rs[WIDTH-1:0] - m) : rs[WIDTH-1:0];
    assign div_next = {rem_next, p[WIDTH-2:0], ge};

    assign step_result = div ? div_next : mul_next;
    assign step_done   = step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p   <= '0;
            m   <= '0;
            div <= 1'b0;
        end else if (load) begin
            div <= op_is_div;
            p   <= op_is_div ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
            m   <= op_is_div ? b : a;
        end else if (step) begin
            p <= step_result;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with ready/start/done handshake, one op in flight.
// Ports: clk, rst (async, active high); start/opcode/a/b request;
// ready idle flag; done one-cycle pulse; result/err held until next done.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         opcode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               err
);

    localparam int CW = $clog2(WIDTH);

    alu_state_e         state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic               done_n;
    logic [2*WIDTH-1:0] result_n;
    logic               err_n;

    alu_op_e            op;
    logic               b_zero;
    logic               load;
    logic               step;
    logic               step_done;
    logic [2*WIDTH-1:0] step_result;
    logic [2*WIDTH-1:0] single_res;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     dif;

    assign op     = alu_op_e'(opcode);
    assign b_zero = (b == '0);
    assign ready  = (state == ST_IDLE);

    // Bit WIDTH of the (WIDTH+1)-bit sum/difference is carry/borrow.
    assign sum = {1'b0, a} + {1'b0, b};
    assign dif = {1'b0, a} - {1'b0, b};

    always_comb begin
        single_res = '0;
        unique case (op)
            OP_ADD: single_res = {{(WIDTH-1){1'b0}}, sum};
            OP_SUB: single_res = {{(WIDTH-1){1'b0}}, dif};
            OP_AND: single_res = {{WIDTH{1'b0}}, a & b};
            OP_OR:  single_res = {{WIDTH{1'b0}}, a | b};
            OP_XOR: single_res = {{WIDTH{1'b0}}, a ^ b};
            OP_DIV: single_res = {a, {WIDTH{1'b1}}};
            OP_NOP,
            OP_MUL: single_res = '0;
        endcase
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        done_n   = 1'b0;
        result_n = result;
        err_n    = err;
        load     = 1'b0;
        step     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    if (is_multicycle(op) && !(op == OP_DIV && b_zero)) begin
                        load    = 1'b1;
                        cnt_n   = '0;
                        state_n = ST_BUSY;
                    end else begin
                        done_n   = 1'b1;
                        result_n = single_res;
                        err_n    = (op == OP_DIV);
                    end
                end
            end
            ST_BUSY: begin
                step = 1'b1;
                if (step_done) begin
                    // cnt counts steps already committed; the step
                    // landing on this edge is the final one at WIDTH-1.
                    if (cnt == CW'(WIDTH-1)) begin
                        cnt_n    = '0;
                        state_n  = ST_IDLE;
                        done_n   = 1'b1;
                        result_n = step_result;
                        err_n    = 1'b0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            done   <= 1'b0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            done   <= done_n;
            result <= result_n;
            err    <= err_n;
        end
    end

    seq_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .step        (step),
        .op_is_div   (op == OP_DIV),
        .a           (a),
        .b           (b),
        .step_done   (step_done),
        .step_result (step_result)
    );

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH = 8): stimulus pushes expected
// result/err/done-cycle; a negedge monitor pops on every done.
module tb_seq_alu;

    localparam int W = 8;

    localparam logic [2:0] NOP = 3'b000;
    localparam logic [2:0] ADD = 3'b001;
    localparam logic [2:0] SUB = 3'b010;
    localparam logic [2:0] AND = 3'b011;
    localparam logic [2:0] OR  = 3'b100;
    localparam logic [2:0] XOR = 3'b101;
    localparam logic [2:0] MUL = 3'b110;
    localparam logic [2:0] DIV = 3'b111;

    logic           clk;
    logic           rst;
    logic           start;
    logic [2:0]     opcode;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           ready;
    logic           done;
    logic [2*W-1:0] result;
    logic           err;

    typedef struct {
        logic [2*W-1:0] res;
        logic           err;
        int             due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .opcode (opcode),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .done   (done),
        .result (result),
        .err    (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: every done must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", 32'(result), 32'(e.res));
                chk("err", 32'(err), 32'(e.err));
                chk("done_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    // Called at a negedge; waits for ready, drives one start for one
    // cycle, then scrambles the operands to prove they were latched.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [2*W-1:0] er,
                         input logic ee, input int extra);
        exp_t e;
        int   n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(ready), 32'(1));
        if (ready) begin
            start  = 1'b1;
            opcode = op;
            a      = x;
            b      = y;
            e.res  = er;
            e.err  = ee;
            e.due  = cyc + 1 + extra;
            q.push_back(e);
            @(negedge clk);
            start  = 1'b0;
            a      = ~x;
            b      = ~y;
            opcode = ~op;
        end
    endtask

    function automatic logic [2*W:0] model(input logic [2:0] op,
                                           input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        logic [2*W-1:0] r;
        logic           e;
        e = 1'b0;
        r = '0;
        case (op)
            ADD: r = (2*W)'(x) + (2*W)'(y);
            SUB: r = {{(W-1){1'b0}}, (x < y), W'(x - y)};
            AND: r = {{W{1'b0}}, x & y};
            OR:  r = {{W{1'b0}}, x | y};
            XOR: r = {{W{1'b0}}, x ^ y};
            MUL: r = (2*W)'(x) * (2*W)'(y);
            DIV: begin
                if (y == 0) begin
                    r = {x, {W{1'b1}}};
                    e = 1'b1;
                end else begin
                    r = {W'(x % y), W'(x / y)};
                end
            end
            default: r = '0;
        endcase
        return {e, r};
    endfunction

    initial begin
        logic [2*W:0] m;
        logic [2:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           ex;

        rst    = 1'b1;
        start  = 1'b0;
        opcode = '0;
        a      = '0;
        b      = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'(1));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_result", 32'(result), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        issue(ADD, 8'hFF, 8'h01, 16'h0100, 1'b0, 0);
        issue(SUB, 8'h05, 8'h07, 16'h01FE, 1'b0, 0);
        issue(SUB, 8'h07, 8'h05, 16'h0002, 1'b0, 0);
        issue(ADD, 8'h80, 8'h7F, 16'h00FF, 1'b0, 0);
        issue(NOP, 8'h12, 8'h34, 16'h0000, 1'b0, 0);
        issue(AND, 8'hF0, 8'h3C, 16'h0030, 1'b0, 0);
        issue(OR,  8'hF0, 8'h3C, 16'h00FC, 1'b0, 0);
        issue(XOR, 8'hF0, 8'h3C, 16'h00CC, 1'b0, 0);

        issue(MUL, 8'hFF, 8'hFF, 16'hFE01, 1'b0, W);
        for (int i = 0; i < W; i++) begin
            chk("busy_ready", 32'(ready), 32'(0));
            if (i == 2) begin
                start  = 1'b1;
                opcode = ADD;
                a      = 8'h01;
                b      = 8'h01;
            end
            @(negedge clk);
            start = 1'b0;
        end
        chk("mul_end_ready", 32'(ready), 32'(1));

        issue(DIV, 8'd200, 8'd7, 16'h041C, 1'b0, W);
        issue(DIV, 8'h33, 8'h00, 16'h33FF, 1'b1, 0);
        issue(MUL, 8'h0D, 8'h0B, 16'h008F, 1'b0, W);
        issue(DIV, 8'h05, 8'h09, 16'h0500, 1'b0, W);

        issue(MUL, 8'h12, 8'h34, 16'h03A8, 1'b0, W);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_ready", 32'(ready), 32'(1));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_result", 32'(result), 32'(0));
        chk("abort_err", 32'(err), 32'(0));
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(ADD, 8'h03, 8'h04, 16'h0007, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(7, 0));
            ra  = W'($urandom);
            rb  = (i % 9 == 0) ? '0 : W'($urandom);
            m   = model(rop, ra, rb);
            ex  = ((rop == MUL) || (rop == DIV && rb != 0)) ? W : 0;
            issue(rop, ra, rb, m[2*W-1:0], m[2*W], ex);
        end

        repeat (W + 4) @(negedge clk);
        chk("pending", 32'(q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised sequential ALU: the successor to the 8-bit start/done ALU, generalised to WIDTH-bit operands. It executes single-cycle add/sub/logic ops and multi-cycle unsigned multiply and divide on one shared iterative datapath, using a ready/start/done handshake. It sits between the operand-issue logic and the result writeback, and accepts at most one operation in flight.

## Interface
- WIDTH, default 8: operand width in bits, must be ≥ 2. Result width is 2*WIDTH.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while ready=1.
- opcode  input  3  operation, sampled with start.
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- ready  output  1  block is idle and can accept start.
- done  output  1  one-cycle pulse: result and err are valid.
- result  output  2*WIDTH  registered result, held until the next done.
- err  output  1  error flag for the completed op, held with result.

## Operation
- Opcodes: 000 NOP, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 MUL, 111 DIV.
- Accept condition: start & ready at a rising edge. Operands and opcode are latched internally at that edge, so later changes on a, b and opcode have no effect on the op in flight.
- NOP: result = 0, err = 0.
- ADD: result[WIDTH:0] = a + b, where bit WIDTH is the carry. All upper bits are 0.
- SUB: result[WIDTH-1:0] = a − b mod 2^WIDTH, result[WIDTH] = borrow (1 when a < b). All upper bits are 0.
- AND/OR/XOR: bitwise on the low WIDTH bits, upper WIDTH bits are 0.
- MUL: unsigned shift-add, one partial product per cycle, full 2*WIDTH-bit product.
- DIV: unsigned restoring division, one quotient bit per cycle. result = {remainder, quotient}.
- DIV with b = 0: no iteration is performed. Completes as a single-cycle op with result = {a, all-ones} and err = 1.
- err is 0 for every case other than DIV with b = 0.
- FSM has two states:
  - IDLE: ready = 1. A single-cycle op or DIV-by-0 stays in IDLE; a MUL or DIV with b ≠ 0 moves to BUSY.
  - BUSY: ready = 0. An iteration counter counts WIDTH steps. The state returns to IDLE on the edge that completes the final step.
- start while BUSY is ignored: it is not queued and does not disturb the op in flight.

## Timing
- Reset values: ready = 1, done = 0, result = 0, err = 0, state = IDLE, counter = 0.
- Single-cycle ops (including NOP and DIV-by-0) have latency 1. Accept at edge k; done = 1 and result/err are valid in the cycle after edge k.
- MUL and DIV have latency WIDTH. Accept at edge k; ready = 0 after edges k … k+WIDTH−1; done = 1 and ready = 1 in the cycle after edge k+WIDTH.
- Back-to-back: a start in the done cycle is accepted, giving throughput of 1 op/cycle for single-cycle ops.
- done is high for exactly one cycle per accepted op and is never asserted without a prior accept.
- Reset mid-operation aborts immediately: no done follows, and all outputs return to reset values.

## Structure
- Shared package alu_pkg:
  - opcode enum (alu_op_e) with the encodings above.
  - helper constants: OP_NOP … OP_DIV.
  - function is_multicycle(op).
- The FSM, handshake and single-cycle ops live in seq_alu.
- Sub-module seq_muldiv (params WIDTH): iterative shift-add multiply / restoring divide engine.
  - Inputs: load, op_is_div, a, b.
  - Outputs: step_done, product/{rem,quot}.
  - seq_alu owns the iteration counter.

## Test plan (WIDTH = 8)
- ADD a=0xFF b=0x01 -> result 0x0100, err 0, done 1 cycle after accept. SUB a=0x05 b=0x07 -> result 0x01FE.
- AND/OR/XOR a=0xF0 b=0x3C -> 0x0030 / 0x00FC / 0x00CC. Back-to-back starts give done on 3 consecutive cycles.
- MUL a=0xFF b=0xFF -> result 0xFE01 with done exactly 8 cycles after accept. ready stays 0 until the done cycle. A start at cycle 3 is ignored.
- DIV a=200 b=7 -> result 0x041C (remainder 4, quotient 28) after 8 cycles. DIV a=0x33 b=0 -> result 0x33FF, err 1, done after 1 cycle.
- Reset asserted mid-MUL (cycle 4) -> no done pulse, ready = 1, result = 0. A new ADD after reset release completes normally.
- Random a, b and op against a reference model -> every accepted op yields exactly one done with the correct result and err.
